// File: rtl/memory_stage_if.sv
// Execute-to-memory stage bus: instruction inputs from execute_stage and the
// stall/result signals returned by memory_stage.
interface memory_stage_if;
  logic        valid_in;
  logic        MemRead;
  logic        MemWrite;
  logic [15:0] ALUO;
  logic [15:0] Rd2;
  logic        stall;
  logic        valid_out;
  logic [15:0] ALUO_out;
  logic [15:0] MemO;
  logic        err;

  modport master (
    output valid_in, MemRead, MemWrite, ALUO, Rd2,
    input  stall, valid_out, ALUO_out, MemO, err
  );

  modport slave (
    input  valid_in, MemRead, MemWrite, ALUO, Rd2,
    output stall, valid_out, ALUO_out, MemO, err
  );
endinterface

// File: rtl/memory_stage.sv
// Memory-access stage: word-organised data memory with LAT busy cycles per
// access, single-cycle pass-through for non-memory ops, sticky error flag.
module memory_stage #(
  parameter int ADDR_W = 8,
  parameter int LAT    = 2
) (
  input  logic           clk,
  input  logic           rst,
  memory_stage_if.slave  bus
);

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_e;

  typedef struct packed {
    logic              is_ld;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       data;
    logic [15:0]       aluo;
  } req_t;

  localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  req_t        req_q, req_d;
  logic        valid_q, valid_d;
  logic [15:0] aluo_q, aluo_d;
  logic [15:0] memo_q, memo_d;
  logic        err_q, err_d;
  logic        stall;
  logic        wr_en;
  logic        memop, bad;

  logic [15:0] mem_q [0:(1<<ADDR_W)-1];

  // Byte-address bits above the word index are deliberately dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^{bus.ALUO[15:ADDR_W+1]};

  assign memop = bus.valid_in & (bus.MemRead | bus.MemWrite);
  assign bad   = memop & (bus.ALUO[0] | (bus.MemRead & bus.MemWrite));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      valid_q <= 1'b0;
      aluo_q  <= '0;
      memo_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      valid_q <= valid_d;
      aluo_q  <= aluo_d;
      memo_q  <= memo_d;
      err_q   <= err_d;
    end
  end

  // Memory is never cleared; reset on the final cycle cancels the write.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem_q[req_q.addr] <= req_q.data;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (memop && !bad) begin
          state_d = S_BUSY;
          cnt_d   = CNT_INIT;
        end
      end
      S_BUSY: begin
        if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
        else               state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath logic
  always_comb begin
    stall   = 1'b0;
    wr_en   = 1'b0;
    req_d   = req_q;
    valid_d = 1'b0;
    aluo_d  = aluo_q;
    memo_d  = memo_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        stall = memop & ~bad;
        if (memop && !bad) begin
          req_d.is_ld = bus.MemRead;
          req_d.addr  = bus.ALUO[ADDR_W:1];
          req_d.data  = bus.Rd2;
          req_d.aluo  = bus.ALUO;
        end else if (bus.valid_in) begin
          // Non-memory and faulting ops both retire next cycle with no access.
          valid_d = 1'b1;
          aluo_d  = bus.ALUO;
          memo_d  = '0;
          err_d   = err_q | bad;
        end
      end
      S_BUSY: begin
        stall = (cnt_q != 4'd0);
        if (cnt_q == 4'd0) begin
          valid_d = 1'b1;
          aluo_d  = req_q.aluo;
          memo_d  = req_q.is_ld ? mem_q[req_q.addr] : 16'h0000;
          wr_en   = ~req_q.is_ld;
        end
      end
      default: ;
    endcase
  end

  assign bus.stall     = stall;
  assign bus.valid_out = valid_q;
  assign bus.ALUO_out  = aluo_q;
  assign bus.MemO      = memo_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_memory_stage.sv
// Directed + randomized bench for memory_stage against a transaction-level model.
module tb_memory_stage;
  localparam int ADDR_W = 8;
  localparam int LAT    = 2;
  localparam int DEPTH  = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  memory_stage_if bus();
  memory_stage #(.ADDR_W(ADDR_W), .LAT(LAT)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] mem_m [DEPTH];
  logic        err_m;
  logic [15:0] aluo_m, memo_m;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit vin, input bit rd, input bit wr,
                       input logic [15:0] a, input logic [15:0] d);
    bus.valid_in = vin;
    bus.MemRead  = rd;
    bus.MemWrite = wr;
    bus.ALUO     = a;
    bus.Rd2      = d;
  endtask

  // Entered and left at posedge+1. Presents one instruction, holds it while
  // stalled, and checks the retired result against the model.
  task automatic issue(input bit vin, input bit rd, input bit wr,
                       input logic [15:0] a, input logic [15:0] d, input string tag);
    bit memop, bad;
    int idx, nstall;
    memop  = vin && (rd || wr);
    bad    = memop && (a[0] || (rd && wr));
    idx    = (int'(a) / 2) % DEPTH;
    nstall = (memop && !bad) ? LAT : 0;
    drive(vin, rd, wr, a, d);
    #1;
    for (int c = 0; c < nstall; c++) begin
      chk1({tag, ".stall_hi"}, bus.stall, 1'b1);
      @(posedge clk); #1;
      chk1({tag, ".busy_valid"}, bus.valid_out, 1'b0);
    end
    chk1({tag, ".stall_lo"}, bus.stall, 1'b0);
    @(posedge clk); #1;
    if (vin) begin
      aluo_m = a;
      memo_m = (memop && !bad && rd) ? mem_m[idx] : 16'h0000;
      if (memop && !bad && wr) mem_m[idx] = d;
      if (bad) err_m = 1'b1;
    end
    chk1({tag, ".valid_out"}, bus.valid_out, vin);
    chk({tag, ".ALUO_out"}, bus.ALUO_out, aluo_m);
    chk({tag, ".MemO"}, bus.MemO, memo_m);
    chk1({tag, ".err"}, bus.err, err_m);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a;
    int kind;
    bit vin;

    // Reset with random inputs
    rst = 1'b1;
    drive(1'b1, 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom));
    repeat (2) @(posedge clk);
    #1;
    chk1("rst.valid_out", bus.valid_out, 1'b0);
    chk("rst.ALUO_out", bus.ALUO_out, 16'h0000);
    chk("rst.MemO", bus.MemO, 16'h0000);
    chk1("rst.err", bus.err, 1'b0);
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    #1;
    chk1("rst.stall", bus.stall, 1'b0);
    err_m = 1'b0; aluo_m = '0; memo_m = '0;
    @(posedge clk); #1;

    // Give every word a known value
    for (int i = 0; i < DEPTH; i++)
      issue(1'b1, 1'b0, 1'b1, 16'(i * 2), 16'($urandom), "init");

    // Non-memory pass-through
    issue(1'b1, 1'b0, 1'b0, 16'h0005, 16'h0, "pass0");
    issue(1'b1, 1'b0, 1'b0, 16'h0002, 16'h0, "pass1");
    chk("pass1.const", bus.ALUO_out, 16'h0002);

    // Store then load
    issue(1'b1, 1'b0, 1'b1, 16'h000A, 16'hBEEF, "st_A");
    issue(1'b1, 1'b1, 1'b0, 16'h000A, 16'h0, "ld_A");
    chk("ld_A.const", bus.MemO, 16'hBEEF);

    // Address wrap
    issue(1'b1, 1'b0, 1'b1, 16'h020A, 16'h1234, "st_wrap");
    issue(1'b1, 1'b1, 1'b0, 16'h000A, 16'h0, "ld_wrap");
    chk("ld_wrap.const", bus.MemO, 16'h1234);

    // Misaligned load, then an ordinary op still retires
    issue(1'b1, 1'b1, 1'b0, 16'h0007, 16'h0, "misalign");
    chk1("misalign.err_const", bus.err, 1'b1);
    issue(1'b1, 1'b0, 1'b0, 16'h0042, 16'h0, "add_after_err");
    issue(1'b1, 1'b1, 1'b1, 16'h0004, 16'h0, "rd_and_wr");
    issue(1'b0, 1'b0, 1'b0, 16'h0099, 16'h0, "bubble");

    // Reset during first BUSY cycle cancels the store
    issue(1'b1, 1'b0, 1'b1, 16'h0010, 16'h5555, "st_pre");
    drive(1'b1, 1'b0, 1'b1, 16'h0010, 16'hAAAA);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    #1;
    chk1("midrst.stall", bus.stall, 1'b0);
    chk1("midrst.valid_out", bus.valid_out, 1'b0);
    chk("midrst.ALUO_out", bus.ALUO_out, 16'h0000);
    chk1("midrst.err", bus.err, 1'b0);
    err_m = 1'b0; aluo_m = '0; memo_m = '0;
    @(posedge clk); #1;
    issue(1'b1, 1'b1, 1'b0, 16'h0010, 16'h0, "ld_after_rst");
    chk("ld_after_rst.const", bus.MemO, 16'h5555);

    // Randomized mix over a small word window so addresses collide
    for (int n = 0; n < 80; n++) begin
      vin  = ($urandom_range(0, 3) != 0);
      kind = $urandom_range(0, 9);
      a    = 16'($urandom) & 16'hFE1E;
      if ($urandom_range(0, 9) == 0) a[0] = 1'b1;
      if (kind <= 3)      issue(vin, 1'b1, 1'b0, a, 16'($urandom), "rnd_ld");
      else if (kind <= 7) issue(vin, 1'b0, 1'b1, a, 16'($urandom), "rnd_st");
      else if (kind == 8) issue(vin, 1'b0, 1'b0, a, 16'($urandom), "rnd_alu");
      else                issue(vin, 1'b1, 1'b1, a, 16'($urandom), "rnd_both");
    end

    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
Memory-access stage of the 16-bit five-stage pipeline. It sits directly downstream of execute_stage and consumes its ALUO result and the Rd2 store data. Loads and stores go to an internal word-organised data memory with configurable multi-cycle latency, and the stage stalls upstream while an access is in flight. Non-memory instructions pass ALUO through in one cycle. Results feed the writeback stage.

Parameters:
ADDR_W, 8, word-address width; memory holds 2^ADDR_W 16-bit words and is indexed by ALUO[ADDR_W:1].
LAT, 2, number of BUSY cycles per memory access (legal range 1..15).

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
valid_in  input  1  instruction from execute_stage is present
MemRead  input  1  instruction is a load (ld)
MemWrite  input  1  instruction is a store (st/stu)
ALUO  input  16  ALU result from execute_stage; byte address for memory ops
Rd2  input  16  store data
stall  output  1  upstream must hold its inputs stable this cycle
valid_out  output  1  registered; one result retired this cycle
ALUO_out  output  16  registered pass-through of the accepted ALUO
MemO  output  16  registered load data; 0 for non-loads
err  output  1  sticky error flag

Behaviour:
- Reset (rst=1 at an edge): state goes to IDLE, counter to 0, and valid_out, ALUO_out, MemO and err go to 0. Memory contents are not cleared. Reset during BUSY aborts the access; a pending store is not written.
- memop = valid_in & (MemRead | MemWrite). bad = memop & (ALUO[0] | (MemRead & MemWrite)).
- stall is combinational. It is 1 in IDLE when memop & ~bad, and 1 in BUSY while cnt != 0. Otherwise it is 0.
- FSM states are IDLE and BUSY.
- IDLE, valid_in=0: next valid_out=0. ALUO_out and MemO hold.
- IDLE, valid_in=1, non-memory op: next valid_out=1, ALUO_out=ALUO, MemO=0. Latency is 1 cycle and throughput is 1 per cycle.
- IDLE, bad: no memory access and no stall. Next valid_out=1, ALUO_out=ALUO, MemO=0, err=1. err stays 1 until reset.
- IDLE, memop & ~bad: latch the address (ALUO[ADDR_W:1]), Rd2 and the op type. Set cnt=LAT-1 and go to BUSY. valid_out=0 next cycle.
- BUSY, cnt != 0: decrement cnt. Inputs are ignored. valid_out=0.
- BUSY, cnt == 0: this is the final cycle and stall=0, so upstream advances at this edge.
  - A store writes mem[addr] = latched data at this edge.
  - A load registers MemO = mem[addr].
  - Next valid_out=1, ALUO_out = latched ALUO, and the FSM returns to IDLE.
- A memory op therefore takes LAT+1 cycles from presentation to valid_out. stall is high for LAT cycles.
- Address bits above ADDR_W are ignored, so addresses wrap modulo 2^(ADDR_W+1) bytes.
- A load immediately after a store to the same address returns the new data, because the write completes before the load's read edge.
- err has no other effect on operation; later instructions still execute.

Test Plan:
1. Reset check: hold rst 2 cycles with random inputs -> valid_out=0, ALUO_out=0, MemO=0, err=0, stall=0.
2. Non-memory pass-through (LAT=2): ALUO=0x0005 then 0x0002 on consecutive cycles, valid_in=1, MemRead=MemWrite=0 -> valid_out=1 on both following cycles, ALUO_out=0x0005 then 0x0002, stall never asserted.
3. Store then load: st ALUO=0x000A, Rd2=0xBEEF -> stall=1 for exactly 2 cycles, valid_out pulses on cycle 3 with MemO=0. Then ld ALUO=0x000A -> stall=1 for 2 cycles, then valid_out=1 with MemO=0xBEEF and ALUO_out=0x000A.
4. Address wrap: st ALUO=0x020A, Rd2=0x1234, then ld ALUO=0x000A -> MemO=0x1234.
5. Misaligned access: ld ALUO=0x0007 -> no stall, next cycle valid_out=1, MemO=0, err=1. err stays 1 through a following valid add, and that add retires normally.
6. Reset mid-access: st ALUO=0x0010, Rd2=0xAAAA, assert rst during the first BUSY cycle -> state returns to IDLE and stall=0. A subsequent ld 0x0010 returns the previously stored value, not 0xAAAA.
